cpu_clk_ctrl: RTL and testbench

Run/step clock-enable controller for the lab CPU. It consumes the divided clock levels from the clock divider, which sit in the same `clk` domain. It selects one rate and turns that source's rising edges into single-cycle `cpu_ce` pulses. It supports free-run and single-step modes, so the CPU core is clocked only by `clk` and gated by `cpu_ce`; no derived clocks are used.

---
 rtl/cpu_clk_ctrl.sv | 121 ++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl.sv
// rtl/cpu_clk_ctrl.sv - run/step clock-enable controller for the lab CPU
// Optional tick counter is built when CPU_CLK_TICKCNT_EN is defined; otherwise tick_cnt reads 0.
module cpu_clk_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       div_in,
    input  logic [1:0]       sel,
    input  logic             run,
    input  logic             step,
    output logic             cpu_ce,
    output logic [1:0]       state,
    output logic             busy,
    output logic [CNT_W-1:0] tick_cnt
);

    localparam logic [1:0] HALT      = 2'b00;
    localparam logic [1:0] RUN       = 2'b01;
    localparam logic [1:0] STEP_WAIT = 2'b10;
    localparam logic [1:0] STEP_DONE = 2'b11;

    logic [2:0] div_q;
    logic [2:0] rise;
    logic       step_q;
    logic       step_rise;
    logic [1:0] sel_q;
    logic       src_rise;
    logic       ev;
    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       ce_d;

    // Divider levels reset high so the first divider edge after reset is not a false rise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q  <= 3'b111;
            step_q <= 1'b1;
            sel_q  <= 2'b00;
        end else begin
            div_q  <= div_in;
            step_q <= step;
            sel_q  <= sel;
        end
    end

    assign rise      = div_in & ~div_q;
    assign step_rise = step & ~step_q;

    always_comb begin
        case (sel_q)
            2'd1:    src_rise = rise[0];
            2'd2:    src_rise = rise[1];
            2'd3:    src_rise = rise[2];
            default: src_rise = 1'b1;
        endcase
    end

    // A rate switch masks the event for one cycle so no partial tick leaks through.
    assign ev = (sel == sel_q) & src_rise;

    always_comb begin
        state_d = state_q;
        ce_d    = 1'b0;
        case (state_q)
            HALT: begin
                if (run)
                    state_d = RUN;
                else if (step_rise)
                    state_d = STEP_WAIT;
            end
            RUN: begin
                if (!run)
                    state_d = HALT;
                else
                    ce_d = ev;
            end
            STEP_WAIT: begin
                if (ev) begin
                    ce_d    = 1'b1;
                    state_d = STEP_DONE;
                end
            end
            default: begin
                if (!step)
                    state_d = run ? RUN : HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= HALT;
            cpu_ce  <= 1'b0;
        end else begin
            state_q <= state_d;
            cpu_ce  <= ce_d;
        end
    end

    assign state = state_q;
    assign busy  = (state_q == STEP_WAIT);

`ifdef CPU_CLK_TICKCNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst)
            cnt_q <= '0;
        else if (cpu_ce)
            cnt_q <= cnt_q + CNT_ONE;
    end

    assign tick_cnt = cnt_q;
`else
    assign tick_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb/tb_cpu_clk_ctrl.sv - randomized self-checking bench for cpu_clk_ctrl
module tb_cpu_clk_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          run = 1'b0;
    logic          step = 1'b0;
    logic [2:0]    div_in = 3'b111;
    logic [1:0]    sel = 2'b00;
    logic          cpu_ce;
    logic [1:0]    state;
    logic          busy;
    logic [CW-1:0] tick_cnt;

    int checks = 0;
    int errors = 0;
    int div_cnt = 7;
    int div_mode = 0;

    cpu_clk_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .div_in(div_in), .sel(sel), .run(run), .step(step),
        .cpu_ce(cpu_ce), .state(state), .busy(busy), .tick_cnt(tick_cnt)
    );

    always #5 clk = ~clk;

    // Reference: mode 0 idle, 1 free-running, 2 waiting for a step tick, 3 step served.
    int            m_mode;
    logic          m_ce;
    int            m_ticks;
    logic [2:0]    p_div;
    logic          p_step;
    logic [1:0]    p_sel;
    logic          src_edge;
    logic          press;
    logic [1:0]    e_state;
    logic          e_busy;
    logic [CW-1:0] e_cnt;

    function automatic logic [1:0] mode_code(input int m);
        case (m)
            1:       return 2'b01;
            2:       return 2'b10;
            3:       return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_mode = 0; m_ce = 1'b0; m_ticks = 0;
            p_div = 3'b111; p_step = 1'b1; p_sel = 2'b00;
        end else begin
            if (m_ce) m_ticks = (m_ticks + 1) % (1 << CW);
            press = step && !p_step;
            if (sel != p_sel) src_edge = 1'b0;
            else if (sel == 2'd0) src_edge = 1'b1;
            else src_edge = div_in[int'(sel) - 1] && !p_div[int'(sel) - 1];
            m_ce = 1'b0;
            case (m_mode)
                0: if (run) m_mode = 1; else if (press) m_mode = 2;
                1: if (!run) m_mode = 0; else m_ce = src_edge;
                2: if (src_edge) begin m_ce = 1'b1; m_mode = 3; end
                default: if (!step) m_mode = run ? 1 : 0;
            endcase
            p_div = div_in; p_step = step; p_sel = sel;
        end
        e_state = mode_code(m_mode);
        e_busy  = (m_mode == 2);
`ifdef CPU_CLK_TICKCNT_EN
        e_cnt = m_ticks[CW-1:0];
`else
        e_cnt = '0;
`endif
    end

    task automatic drive(input logic rn, input logic r, input logic [1:0] s, input logic st);
        rst = rn; run = r; sel = s; step = st;
        if (!rn) div_cnt = 7; else div_cnt = (div_cnt + 1) % 8;
        case (div_mode)
            0:       div_in = div_cnt[2:0];
            1:       div_in = 3'($urandom);
            default: div_in = 3'b000;
        endcase
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'($urandom), 2'($urandom), 1'($urandom));
            @(negedge clk);
            checks++;
            if (cpu_ce !== 1'b0 || state !== 2'b00 || busy !== 1'b0 || tick_cnt !== '0) begin
                errors++;
                $display("FAIL reset ce=%b state=%b busy=%b cnt=%0d expected 0 00 0 0", cpu_ce, state, busy, tick_cnt);
            end
        end
    endtask

    task automatic test_run_free();
        int pulses = 0;
        logic [CW-1:0] want;
`ifdef CPU_CLK_TICKCNT_EN
        want = 4'd10;
`else
        want = '0;
`endif
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b1, 2'd0, 1'b0);
            @(negedge clk);
            checks++;
            if (cpu_ce !== m_ce || state !== e_state || busy !== e_busy || tick_cnt !== e_cnt) begin
                errors++;
                $display("FAIL run_free cyc=%0d ce=%b/%b state=%b/%b busy=%b/%b cnt=%0d/%0d", i, cpu_ce, m_ce, state, e_state, busy, e_busy, tick_cnt, e_cnt);
            end
            if (cpu_ce) pulses++;
        end
        checks++;
        if (pulses != 11) begin errors++; $display("FAIL run_free_pulses got %0d expected 11", pulses); end
        checks++;
        if (state !== 2'b01) begin errors++; $display("FAIL run_free_state got %b expected 01", state); end
        checks++;
        if (tick_cnt !== want) begin errors++; $display("FAIL run_free_cnt got %0d expected %0d", tick_cnt, want); end
    endtask

    task automatic test_run_div();
        int pulses = 0;
        int last = -1;
        div_mode = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b1, 2'd2, 1'b0);
            @(negedge clk);
            checks++;
            if (cpu_ce !== m_ce || state !== e_state || busy !== e_busy || tick_cnt !== e_cnt) begin
                errors++;
                $display("FAIL run_div cyc=%0d ce=%b/%b state=%b/%b busy=%b/%b cnt=%0d/%0d", i, cpu_ce, m_ce, state, e_state, busy, e_busy, tick_cnt, e_cnt);
            end
            if (cpu_ce) begin
                if (last >= 0) begin
                    checks++;
                    if (i - last != 4) begin errors++; $display("FAIL run_div_gap got %0d expected 4", i - last); end
                end
                last = i;
                pulses++;
            end
        end
        checks++;
        if (pulses < 9) begin errors++; $display("FAIL run_div_pulses got %0d expected >= 9", pulses); end
    endtask

    task automatic test_step_sel3();
        int pulses = 0;
        int saw = -10;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 2'd3, 1'b0);
            @(negedge clk);
            checks++;
            if (cpu_ce !== m_ce || state !== e_state || busy !== e_busy || tick_cnt !== e_cnt) begin
                errors++;
                $display("FAIL step_settle cyc=%0d ce=%b/%b state=%b/%b busy=%b/%b cnt=%0d/%0d", i, cpu_ce, m_ce, state, e_state, busy, e_busy, tick_cnt, e_cnt);
            end
        end
        drive(1'b1, 1'b0, 2'd3, 1'b1);
        @(negedge clk);
        checks++;
        if (state !== 2'b10 || busy !== 1'b1) begin
            errors++; $display("FAIL step_wait state=%b busy=%b expected 10 1", state, busy);
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 2'd3, 1'b0);
            @(negedge clk);
            checks++;
            if (cpu_ce !== m_ce || state !== e_state || busy !== e_busy || tick_cnt !== e_cnt) begin
                errors++;
                $display("FAIL step_seq cyc=%0d ce=%b/%b state=%b/%b busy=%b/%b cnt=%0d/%0d", i, cpu_ce, m_ce, state, e_state, busy, e_busy, tick_cnt, e_cnt);
            end
            if (i == saw + 1) begin
                checks++;
                if (state !== 2'b00) begin errors++; $display("FAIL step_back_halt got %b expected 00", state); end
            end
            if (cpu_ce) begin
                pulses++;
                saw = i;
                checks++;
                if (state !== 2'b11) begin errors++; $display("FAIL step_done got %b expected 11", state); end
            end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL step_pulses got %0d expected 1", pulses); end
    endtask

    task automatic test_step_held();
        int p1 = 0;
        int p2 = 0;
        int p3 = 0;
        for (int i = 0; i < 68; i++) begin
            if (i < 3)       drive(1'b1, 1'b0, 2'd1, 1'b0);
            else if (i < 53) drive(1'b1, 1'b0, 2'd1, 1'b1);
            else if (i < 58) drive(1'b1, 1'b0, 2'd1, 1'b0);
            else             drive(1'b1, 1'b0, 2'd1, 1'b1);
            @(negedge clk);
            checks++;
            if (cpu_ce !== m_ce || state !== e_state || busy !== e_busy || tick_cnt !== e_cnt) begin
                errors++;
                $display("FAIL step_held cyc=%0d ce=%b/%b state=%b/%b busy=%b/%b cnt=%0d/%0d", i, cpu_ce, m_ce, state, e_state, busy, e_busy, tick_cnt, e_cnt);
            end
            if (cpu_ce) begin
                if (i < 53) p1++; else if (i < 58) p2++; else p3++;
            end
            if (i == 52) begin
                checks++;
                if (state !== 2'b11) begin errors++; $display("FAIL held_state got %b expected 11", state); end
            end
            if (i == 57) begin
                checks++;
                if (state !== 2'b00) begin errors++; $display("FAIL held_release got %b expected 00", state); end
            end
        end
        checks++;
        if (p1 != 1 || p2 != 0 || p3 != 1) begin
            errors++; $display("FAIL held_pulses got %0d %0d %0d expected 1 0 1", p1, p2, p3);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 2'd1, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic test_sel_switch();
        logic [2:0] d_prev;
        logic [2:0] d_last;
        logic       seen = 1'b0;
        div_mode = 0;
        for (int i = 0; i < 8; i++) begin
            if (i >= 6 && (((div_cnt + 1) % 8) % 2) == 1) break;
            drive(1'b1, 1'b1, 2'd1, 1'b0);
            @(negedge clk);
            checks++;
            if (cpu_ce !== m_ce || state !== e_state || busy !== e_busy || tick_cnt !== e_cnt) begin
                errors++;
                $display("FAIL switch_pre cyc=%0d ce=%b/%b state=%b/%b busy=%b/%b cnt=%0d/%0d", i, cpu_ce, m_ce, state, e_state, busy, e_busy, tick_cnt, e_cnt);
            end
        end
        drive(1'b1, 1'b1, 2'd3, 1'b0);
        d_last = div_in;
        @(negedge clk);
        checks++;
        if (cpu_ce !== 1'b0 || d_last[0] !== 1'b1) begin
            errors++; $display("FAIL switch_cycle ce=%b div=%b expected ce 0 on div0 rise", cpu_ce, d_last);
        end
        for (int i = 0; i < 16; i++) begin
            d_prev = d_last;
            drive(1'b1, 1'b1, 2'd3, 1'b0);
            d_last = div_in;
            @(negedge clk);
            checks++;
            if (cpu_ce !== m_ce || state !== e_state || busy !== e_busy || tick_cnt !== e_cnt) begin
                errors++;
                $display("FAIL switch_post cyc=%0d ce=%b/%b state=%b/%b busy=%b/%b cnt=%0d/%0d", i, cpu_ce, m_ce, state, e_state, busy, e_busy, tick_cnt, e_cnt);
            end
            if (cpu_ce && !seen) begin
                seen = 1'b1;
                checks++;
                if (!(d_last[2] && !d_prev[2])) begin
                    errors++; $display("FAIL switch_align div prev=%b last=%b expected div2 rise", d_prev, d_last);
                end
            end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL switch_no_pulse got 0 pulses expected 1+"); end
    endtask

    task automatic test_wrap();
        logic [CW-1:0] w15, w0, w1;
`ifdef CPU_CLK_TICKCNT_EN
        w15 = 4'd15; w0 = 4'd0; w1 = 4'd1;
`else
        w15 = '0; w0 = '0; w1 = '0;
`endif
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 2'd0, 1'b0);
            @(negedge clk);
        end
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 1'b1, 2'd0, 1'b0);
            @(negedge clk);
            checks++;
            if (cpu_ce !== m_ce || state !== e_state || busy !== e_busy || tick_cnt !== e_cnt) begin
                errors++;
                $display("FAIL wrap cyc=%0d ce=%b/%b state=%b/%b busy=%b/%b cnt=%0d/%0d", i, cpu_ce, m_ce, state, e_state, busy, e_busy, tick_cnt, e_cnt);
            end
            if (i == 16) begin
                checks++;
                if (tick_cnt !== w15) begin errors++; $display("FAIL wrap_15 got %0d expected %0d", tick_cnt, w15); end
            end
            if (i == 17) begin
                checks++;
                if (tick_cnt !== w0) begin errors++; $display("FAIL wrap_0 got %0d expected %0d", tick_cnt, w0); end
            end
        end
        drive(1'b1, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (tick_cnt !== w1 || cpu_ce !== 1'b0) begin
            errors++; $display("FAIL wrap_1 cnt=%0d ce=%b expected %0d 0", tick_cnt, cpu_ce, w1);
        end
    endtask

    task automatic test_reset_mid_step();
        div_mode = 2;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 2'd3, 1'b0);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 2'd3, 1'b1);
            @(negedge clk);
            checks++;
            if (state !== 2'b10 || busy !== 1'b1 || cpu_ce !== 1'b0) begin
                errors++; $display("FAIL midstep_wait cyc=%0d state=%b busy=%b ce=%b expected 10 1 0", i, state, busy, cpu_ce);
            end
        end
        drive(1'b0, 1'b1, 2'd3, 1'b1);
        @(negedge clk);
        checks++;
        if (cpu_ce !== 1'b0 || state !== 2'b00 || busy !== 1'b0 || tick_cnt !== '0) begin
            errors++; $display("FAIL midstep_reset ce=%b state=%b busy=%b cnt=%0d expected 0 00 0 0", cpu_ce, state, busy, tick_cnt);
        end
        drive(1'b1, 1'b0, 2'd3, 1'b1);
        @(negedge clk);
        checks++;
        if (state !== 2'b00) begin errors++; $display("FAIL held_through_reset got %b expected 00", state); end
        div_mode = 0;
    endtask

    task automatic test_random();
        logic r = 1'b0;
        logic [1:0] s = 2'd0;
        logic st = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            div_mode = (i / 250) % 2;
            if ($urandom_range(0, 15) == 0) r = ~r;
            if ($urandom_range(0, 9) == 0) s = 2'($urandom);
            if ($urandom_range(0, 5) == 0) st = ~st;
            drive(($urandom_range(0, 199) != 0), r, s, st);
            @(negedge clk);
            checks++;
            if (cpu_ce !== m_ce || state !== e_state || busy !== e_busy || tick_cnt !== e_cnt) begin
                errors++;
                $display("FAIL random cyc=%0d ce=%b/%b state=%b/%b busy=%b/%b cnt=%0d/%0d", i, cpu_ce, m_ce, state, e_state, busy, e_busy, tick_cnt, e_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_free();
        test_run_div();
        test_step_sel3();
        test_step_held();
        test_sel_switch();
        test_wrap();
        test_reset_mid_step();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
